// File: rtl/isa_frame_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : isa_frame_port
// Purpose  : Framed byte port on an 8-bit ISA I/O bus.
//            - Host writes W_BYTES bytes and then an XOR checksum byte to
//              ADDR_PROC. A good checksum commits the frame to wr_frame_out.
//            - A read of ADDR_RST snapshots rd_frame_in. R_BYTES reads of
//              ADDR_PROC then return the frame bytes, followed by their XOR.
//            - ADDR_STAT returns error, overflow, busy and done flags.
// Ports    : clk_in, rst_in             single clock, sync active-high reset
//            isa_data_io                ISA data bus (bidirectional)
//            isa_tr_data_out            transceiver dir (1 = bus->FPGA)
//            isa_aen_in, isa_addr_in    address enable / address
//            isa_iow_in, isa_ior_in     active-low write / read strobes
//            wr_frame_out, wr_valid_out committed write frame + commit pulse
//            rd_frame_in, rd_snap_out   read frame source + snapshot pulse
// Revision : 1.0 - initial release
// ============================================================================
module isa_frame_port #(
  parameter int         W_BYTES   = 10,
  parameter int         R_BYTES   = 26,
  parameter logic [9:0] ADDR_RST  = 10'h100,
  parameter logic [9:0] ADDR_PROC = 10'h101,
  parameter logic [9:0] ADDR_STAT = 10'h102
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  inout  wire  [7:0]             isa_data_io,
  output logic                   isa_tr_data_out,
  input  logic                   isa_aen_in,
  input  logic [9:0]             isa_addr_in,
  input  logic                   isa_iow_in,
  input  logic                   isa_ior_in,
  output logic [8*W_BYTES-1:0]   wr_frame_out,
  output logic                   wr_valid_out,
  input  logic [8*R_BYTES-1:0]   rd_frame_in,
  output logic                   rd_snap_out
);

  localparam int WCW = $clog2(W_BYTES + 2);
  localparam int RCW = $clog2(R_BYTES + 2);
  localparam logic [WCW-1:0] WCNT_FULL = WCW'(W_BYTES);
  localparam logic [WCW-1:0] WCNT_LOCK = WCW'(W_BYTES + 1);
  localparam logic [RCW-1:0] RCNT_FULL = RCW'(R_BYTES);
  localparam logic [RCW-1:0] RCNT_DONE = RCW'(R_BYTES + 1);

  // Strobe synchronisers: [0] and [1] are the two sync flops, [2] is the
  // delayed copy used for edge detection.
  logic [2:0] iow_sync_q;
  logic [2:0] ior_sync_q;

  logic [7:0]           wr_data_q;
  logic [8*W_BYTES-1:0] stg_q;
  logic [8*W_BYTES-1:0] wr_frame_q;
  logic [WCW-1:0]       wr_cnt_q;
  logic [7:0]           wr_xor_q;
  logic                 wr_valid_q;
  logic                 crc_err_q;
  logic                 ovf_q;

  logic [8*R_BYTES-1:0] rd_buf_q;
  logic [RCW-1:0]       rd_cnt_q;
  logic [7:0]           rd_xor_q;
  logic                 rd_snap_q;
  logic [7:0]           rd_data_q;
  logic                 tr_q;

  logic       wr_end_d;
  logic       rd_start_d;
  logic       rd_end_d;
  logic       hit_rst_d;
  logic       hit_proc_d;
  logic       hit_stat_d;
  logic [7:0] proc_byte_d;
  logic [7:0] stat_byte_d;
  logic [7:0] rd_byte_d;

  assign wr_end_d   =  iow_sync_q[1] & ~iow_sync_q[2];
  assign rd_start_d = ~ior_sync_q[1] &  ior_sync_q[2];
  assign rd_end_d   =  ior_sync_q[1] & ~ior_sync_q[2];

  assign hit_rst_d  = ~isa_aen_in && (isa_addr_in == ADDR_RST);
  assign hit_proc_d = ~isa_aen_in && (isa_addr_in == ADDR_PROC);
  assign hit_stat_d = ~isa_aen_in && (isa_addr_in == ADDR_STAT);

  // Byte the host sees on ADDR_PROC for the current read position.
  always_comb begin
    proc_byte_d = 8'h00;
    if (rd_cnt_q < RCNT_FULL) begin
      for (int k = 0; k < R_BYTES; k++) begin
        if (rd_cnt_q == RCW'(k)) proc_byte_d = rd_buf_q[8*k +: 8];
      end
    end else if (rd_cnt_q == RCNT_FULL) begin
      proc_byte_d = rd_xor_q;
    end
  end

  assign stat_byte_d = {crc_err_q,
                        ovf_q,
                        (wr_cnt_q != '0) && (wr_cnt_q <= WCNT_FULL),
                        (rd_cnt_q > RCNT_FULL),
                        4'h1};

  always_comb begin
    rd_byte_d = 8'h00;
    if (hit_rst_d)       rd_byte_d = 8'hA5;
    else if (hit_proc_d) rd_byte_d = proc_byte_d;
    else if (hit_stat_d) rd_byte_d = stat_byte_d;
  end

  // Synchronisers. Under reset all three stages follow the pin so that a
  // strobe level change during reset does not appear as an edge afterwards.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      iow_sync_q <= {3{isa_iow_in}};
      ior_sync_q <= {3{isa_ior_in}};
    end else begin
      iow_sync_q <= {iow_sync_q[1:0], isa_iow_in};
      ior_sync_q <= {ior_sync_q[1:0], isa_ior_in};
    end
  end

  // Write data is captured while the strobe is still seen low at the first
  // sync stage, so the byte is taken inside the strobe window rather than
  // after the host may have released the bus.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_data_q <= 8'h00;
    end else if (!iow_sync_q[0]) begin
      wr_data_q <= isa_data_io;
    end
  end

  // Write path
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stg_q      <= '0;
      wr_frame_q <= '0;
      wr_cnt_q   <= '0;
      wr_xor_q   <= 8'h00;
      wr_valid_q <= 1'b0;
      crc_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_valid_q <= 1'b0;
      if (wr_end_d) begin
        if (hit_rst_d) begin
          wr_cnt_q  <= '0;
          wr_xor_q  <= 8'h00;
          crc_err_q <= 1'b0;
          ovf_q     <= 1'b0;
        end else if (hit_proc_d) begin
          if (wr_cnt_q < WCNT_FULL) begin
            for (int k = 0; k < W_BYTES; k++) begin
              if (wr_cnt_q == WCW'(k)) stg_q[8*k +: 8] <= wr_data_q;
            end
            wr_xor_q <= wr_xor_q ^ wr_data_q;
            wr_cnt_q <= wr_cnt_q + WCW'(1);
          end else if (wr_cnt_q == WCNT_FULL) begin
            // Checksum byte: commit on match, flag error otherwise; either
            // way the frame is locked until the next restart.
            if (wr_data_q == wr_xor_q) begin
              wr_frame_q <= stg_q;
              wr_valid_q <= 1'b1;
            end else begin
              crc_err_q <= 1'b1;
            end
            wr_cnt_q <= WCNT_LOCK;
          end else begin
            ovf_q <= 1'b1;
          end
        end
      end
    end
  end

  // Read path
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_buf_q  <= '0;
      rd_cnt_q  <= '0;
      rd_xor_q  <= 8'h00;
      rd_snap_q <= 1'b0;
      rd_data_q <= 8'h00;
      tr_q      <= 1'b1;
    end else begin
      rd_snap_q <= 1'b0;
      if (rd_start_d && (hit_rst_d || hit_proc_d || hit_stat_d)) begin
        tr_q      <= 1'b0;
        rd_data_q <= rd_byte_d;
      end
      if (rd_end_d) begin
        // Any end-of-read releases the bus, decoded or not.
        tr_q <= 1'b1;
        if (hit_rst_d) begin
          rd_buf_q  <= rd_frame_in;
          rd_cnt_q  <= '0;
          rd_xor_q  <= 8'h00;
          rd_snap_q <= 1'b1;
        end else if (hit_proc_d) begin
          if (rd_cnt_q < RCNT_FULL) rd_xor_q <= rd_xor_q ^ proc_byte_d;
          if (rd_cnt_q != RCNT_DONE) rd_cnt_q <= rd_cnt_q + RCW'(1);
        end
      end
    end
  end

  assign isa_data_io     = tr_q ? 8'hzz : rd_data_q;
  assign isa_tr_data_out = tr_q;
  assign wr_frame_out    = wr_frame_q;
  assign wr_valid_out    = wr_valid_q;
  assign rd_snap_out     = rd_snap_q;

endmodule
`default_nettype wire

// File: tb/tb_isa_frame_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_isa_frame_port
// Purpose  : Directed self-checking bench for isa_frame_port. Two instances
//            share the ISA strobes and address: A uses default sizes at
//            0x100..0x102, B uses W_BYTES=3 / R_BYTES=4 at 0x200..0x202.
// Revision : 1.0 - initial release
// ============================================================================
module tb_isa_frame_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       aen;
  logic       iow;
  logic       ior;
  logic [9:0] addr;
  logic       tb_drv;
  logic [7:0] tb_data;

  wire  [7:0] bus_a;
  wire  [7:0] bus_b;
  assign bus_a = tb_drv ? tb_data : 8'hzz;
  assign bus_b = tb_drv ? tb_data : 8'hzz;

  logic [79:0]  wr_frame_a;
  logic         wr_valid_a, tr_a, snap_a;
  logic [207:0] rd_frame_a;
  logic [23:0]  wr_frame_b;
  logic         wr_valid_b, tr_b, snap_b;
  logic [31:0]  rd_frame_b;

  int n_assert = 0;
  int n_fail   = 0;
  int n_valid_a = 0, n_snap_a = 0, n_valid_b = 0, n_snap_b = 0;

  logic [7:0] rdv;

  isa_frame_port u_dut_a (
    .clk_in(clk), .rst_in(rst), .isa_data_io(bus_a), .isa_tr_data_out(tr_a),
    .isa_aen_in(aen), .isa_addr_in(addr), .isa_iow_in(iow), .isa_ior_in(ior),
    .wr_frame_out(wr_frame_a), .wr_valid_out(wr_valid_a),
    .rd_frame_in(rd_frame_a), .rd_snap_out(snap_a)
  );

  isa_frame_port #(
    .W_BYTES(3), .R_BYTES(4),
    .ADDR_RST(10'h200), .ADDR_PROC(10'h201), .ADDR_STAT(10'h202)
  ) u_dut_b (
    .clk_in(clk), .rst_in(rst), .isa_data_io(bus_b), .isa_tr_data_out(tr_b),
    .isa_aen_in(aen), .isa_addr_in(addr), .isa_iow_in(iow), .isa_ior_in(ior),
    .wr_frame_out(wr_frame_b), .wr_valid_out(wr_valid_b),
    .rd_frame_in(rd_frame_b), .rd_snap_out(snap_b)
  );

  // Pulse counters (values are stable across the posedge they are sampled on)
  always @(posedge clk) begin
    if (wr_valid_a) n_valid_a++;
    if (snap_a)     n_snap_a++;
    if (wr_valid_b) n_valid_b++;
    if (snap_b)     n_snap_b++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic isa_wr(input logic [9:0] a, input logic [7:0] d, input logic dma);
    @(negedge clk);
    addr = a; aen = dma; tb_data = d; tb_drv = 1'b1;
    @(negedge clk);
    iow = 1'b0;
    repeat (4) @(negedge clk);
    iow = 1'b1;
    repeat (5) @(negedge clk);
    tb_drv = 1'b0; aen = 1'b0;
  endtask

  task automatic isa_rd(input logic [9:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; aen = 1'b0; tb_drv = 1'b0;
    @(negedge clk);
    ior = 1'b0;
    repeat (5) @(negedge clk);
    d = a[9] ? bus_b : bus_a;
    chk("tr_during_read", {127'd0, (a[9] ? tr_b : tr_a)}, 128'd0);
    ior = 1'b1;
    repeat (5) @(negedge clk);
    chk("tr_after_read", {127'd0, (a[9] ? tr_b : tr_a)}, 128'd1);
  endtask

  initial begin
    rst = 1'b1; aen = 1'b0; iow = 1'b1; ior = 1'b1; addr = 10'h000;
    tb_drv = 1'b0; tb_data = 8'h00;
    rd_frame_a = '0; rd_frame_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_tr_a", {127'd0, tr_a}, 128'd1);
    chk("rst_frame_a", {48'd0, wr_frame_a}, 128'd0);
    chk("rst_valid_a", {127'd0, wr_valid_a}, 128'd0);
    chk("rst_snap_a", {127'd0, snap_a}, 128'd0);
    isa_rd(10'h102, rdv);
    chk("rst_stat_a", {120'd0, rdv}, 128'h01);

    // Good frame 01..0A, checksum 0B
    isa_wr(10'h100, 8'h00, 1'b0);
    for (int k = 1; k <= 10; k++) isa_wr(10'h101, 8'(k), 1'b0);
    isa_rd(10'h102, rdv);
    chk("stat_busy_full", {120'd0, rdv}, 128'h21);
    isa_wr(10'h101, 8'h0B, 1'b0);
    chk("good_commits", 128'(n_valid_a), 128'd1);
    chk("good_frame", {48'd0, wr_frame_a}, {48'd0, 80'h0A090807060504030201});

    // Same frame, bad checksum 0C, then overflow
    isa_wr(10'h100, 8'h00, 1'b0);
    for (int k = 1; k <= 10; k++) isa_wr(10'h101, 8'(k), 1'b0);
    isa_wr(10'h101, 8'h0C, 1'b0);
    chk("bad_no_commit", 128'(n_valid_a), 128'd1);
    chk("bad_frame_kept", {48'd0, wr_frame_a}, {48'd0, 80'h0A090807060504030201});
    isa_rd(10'h102, rdv);
    chk("stat_crc_err", {120'd0, rdv}, 128'h81);
    isa_wr(10'h101, 8'h77, 1'b0);
    isa_rd(10'h102, rdv);
    chk("stat_ovf", {120'd0, rdv}, 128'hC1);

    // DMA cycle (AEN=1) ignored
    isa_wr(10'h100, 8'h00, 1'b0);
    isa_rd(10'h102, rdv);
    chk("stat_after_restart", {120'd0, rdv}, 128'h01);
    isa_wr(10'h101, 8'h33, 1'b1);
    isa_rd(10'h102, rdv);
    chk("stat_aen_ignored", {120'd0, rdv}, 128'h01);
    isa_wr(10'h101, 8'h33, 1'b0);
    isa_rd(10'h102, rdv);
    chk("stat_busy_one", {120'd0, rdv}, 128'h21);

    // Read frame 00..19 ; XOR of 0..25 = 01
    for (int k = 0; k < 26; k++) rd_frame_a[8*k +: 8] = 8'(k);
    isa_rd(10'h100, rdv);
    chk("rd_rst_a5", {120'd0, rdv}, 128'hA5);
    chk("snap_count", 128'(n_snap_a), 128'd1);
    rd_frame_a = {26{8'hFF}};
    for (int k = 0; k < 26; k++) begin
      isa_rd(10'h101, rdv);
      chk("rd_byte", {120'd0, rdv}, 128'(k));
    end
    isa_rd(10'h101, rdv);
    chk("rd_xor", {120'd0, rdv}, 128'h01);
    isa_rd(10'h101, rdv);
    chk("rd_past_end", {120'd0, rdv}, 128'h00);
    isa_rd(10'h101, rdv);
    chk("rd_saturated", {120'd0, rdv}, 128'h00);
    isa_rd(10'h102, rdv);
    chk("stat_rd_done", {120'd0, rdv}, 128'h31);

    // Reset mid-frame, then a full new frame 10..A0 with checksum B0
    isa_wr(10'h100, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) isa_wr(10'h101, 8'(8'hFF - k), 1'b0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_frame", {48'd0, wr_frame_a}, 128'd0);
    chk("mid_rst_tr", {127'd0, tr_a}, 128'd1);
    isa_rd(10'h102, rdv);
    chk("mid_rst_stat", {120'd0, rdv}, 128'h01);
    for (int k = 1; k <= 10; k++) isa_wr(10'h101, 8'(k * 16), 1'b0);
    isa_wr(10'h101, 8'hB0, 1'b0);
    chk("new_frame_commit", 128'(n_valid_a), 128'd2);
    chk("new_frame_data", {48'd0, wr_frame_a}, {48'd0, 80'hA0908070605040302010});

    // Small instance: W=3, R=4
    isa_wr(10'h200, 8'h00, 1'b0);
    isa_wr(10'h201, 8'h01, 1'b0);
    isa_wr(10'h201, 8'h02, 1'b0);
    isa_wr(10'h201, 8'h03, 1'b0);
    isa_rd(10'h202, rdv);
    chk("b_stat_full", {120'd0, rdv}, 128'h21);
    isa_wr(10'h201, 8'h00, 1'b0);
    chk("b_commit", 128'(n_valid_b), 128'd1);
    chk("b_frame", {104'd0, wr_frame_b}, 128'h030201);
    isa_rd(10'h202, rdv);
    chk("b_stat_locked", {120'd0, rdv}, 128'h01);
    isa_wr(10'h201, 8'h55, 1'b0);
    isa_rd(10'h202, rdv);
    chk("b_stat_ovf", {120'd0, rdv}, 128'h41);
    chk("a_unaffected", 128'(n_valid_a), 128'd2);

    rd_frame_b = 32'h44332211;
    isa_rd(10'h200, rdv);
    chk("b_rd_a5", {120'd0, rdv}, 128'hA5);
    chk("b_snap", 128'(n_snap_b), 128'd1);
    isa_rd(10'h201, rdv); chk("b_rd0", {120'd0, rdv}, 128'h11);
    isa_rd(10'h201, rdv); chk("b_rd1", {120'd0, rdv}, 128'h22);
    isa_rd(10'h201, rdv); chk("b_rd2", {120'd0, rdv}, 128'h33);
    isa_rd(10'h201, rdv); chk("b_rd3", {120'd0, rdv}, 128'h44);
    isa_rd(10'h201, rdv); chk("b_rd_xor", {120'd0, rdv}, 128'h44);
    isa_rd(10'h201, rdv); chk("b_rd_end", {120'd0, rdv}, 128'h00);
    isa_rd(10'h202, rdv);
    chk("b_stat_done", {120'd0, rdv}, 128'h51);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/isa_frame_port.md
ISA_FRAME_PORT -- requirements
Module: isa_frame_port

Interface
REQ-001 SHALL have parameter W_BYTES, default 10, meaning number of payload bytes in one host-to-FPGA write frame (2..64).
REQ-002 SHALL have parameter R_BYTES, default 26, meaning number of payload bytes in one FPGA-to-host read frame (2..64).
REQ-003 SHALL have parameter ADDR_RST, default 10'h100, meaning the frame restart / snapshot address.
REQ-004 SHALL have parameter ADDR_PROC, default 10'h101, meaning the frame data address.
REQ-005 SHALL have parameter ADDR_STAT, default 10'h102, meaning the status byte address.
REQ-006 SHALL have port clk_in, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port isa_data_io, inout, 8 bits: ISA data bus.
REQ-009 SHALL have port isa_tr_data_out, output, 1 bit: transceiver direction, 1 = bus to FPGA, 0 = FPGA drives.
REQ-010 SHALL have port isa_aen_in, input, 1 bit: address enable; high marks a DMA cycle and blocks decoding.
REQ-011 SHALL have port isa_addr_in, input, 10 bits: ISA address.
REQ-012 SHALL have port isa_iow_in, input, 1 bit: active-low write strobe.
REQ-013 SHALL have port isa_ior_in, input, 1 bit: active-low read strobe.
REQ-014 SHALL have port wr_frame_out, output, 8*W_BYTES bits: last committed write frame; byte k at bits [8k+7:8k].
REQ-015 SHALL have port wr_valid_out, output, 1 bit: one-cycle pulse on commit.
REQ-016 SHALL have port rd_frame_in, input, 8*R_BYTES bits: data captured at snapshot; byte k at bits [8k+7:8k].
REQ-017 SHALL have port rd_snap_out, output, 1 bit: one-cycle pulse when the snapshot is taken.

Function
REQ-018 SHALL pass isa_iow_in and isa_ior_in through 2-flop synchronisers; the rising (end-of-strobe) edge SHALL be flagged 3 clk_in cycles after the pin edge, and the falling edge likewise.
REQ-019 SHALL decode an access only when isa_aen_in=0 and isa_addr_in matches, sampled in the edge-flag cycle; all other addresses SHALL be ignored.
REQ-020 SHALL, on a write to ADDR_RST: set wr_cnt=0 and wr_xor=0, and clear the crc_err and ovf flags; wr_frame_out SHALL be unchanged.
REQ-021 SHALL, on a write to ADDR_PROC while wr_cnt<W_BYTES: store the byte into staging byte[wr_cnt], set wr_xor^=byte, and increment wr_cnt.
REQ-022 SHALL, on a write to ADDR_PROC while wr_cnt=W_BYTES, treat the byte as checksum: if it equals wr_xor, copy staging to wr_frame_out and pulse wr_valid_out in the next cycle; otherwise set crc_err and leave wr_frame_out unchanged. In both cases wr_cnt SHALL become W_BYTES+1 (locked).
REQ-023 SHALL, on a write to ADDR_PROC while locked: ignore the byte and set ovf.
REQ-024 SHALL, on a read-end edge at ADDR_RST: copy rd_frame_in to rd_buf, set rd_cnt=0 and rd_xor=0, and pulse rd_snap_out for one cycle.
REQ-025 SHALL present read data on ADDR_PROC as:
- rd_buf byte[rd_cnt] while rd_cnt<R_BYTES;
- rd_xor when rd_cnt=R_BYTES;
- 8'h00 when rd_cnt>R_BYTES.
REQ-026 SHALL, on a read-end edge at ADDR_PROC: if rd_cnt<R_BYTES, set rd_xor^=presented byte; then increment rd_cnt, saturating at R_BYTES+1.
REQ-027 SHALL return the following on an ADDR_STAT read, with no side effects:
- bit 7: crc_err;
- bit 6: ovf;
- bit 5: write busy (0<wr_cnt≤W_BYTES);
- bit 4: read done (rd_cnt>R_BYTES);
- bits 3:0: 4'h1.
REQ-028 SHALL return 8'hA5 on an ADDR_RST read.
REQ-029 SHALL drive isa_tr_data_out=0 from the decoded read-start edge until the read-end edge, and =1 otherwise.
REQ-030 SHALL drive isa_data_io from a registered read byte only while isa_tr_data_out=0, and high-Z otherwise.
REQ-031 SHALL process simultaneous write and read edges independently in the same cycle.
REQ-032 SHALL size counters as clog2(BYTES+2) bits.

Reset
REQ-033 SHALL, when rst_in=1 at a clk_in edge, set:
- isa_tr_data_out=1 and isa_data_io high-Z;
- wr_frame_out, staging, rd_buf, wr_xor and rd_xor to 0;
- wr_cnt and rd_cnt to 0;
- crc_err and ovf to 0;
- wr_valid_out and rd_snap_out to 0.
REQ-034 SHALL abandon any frame in progress on reset mid-frame, emit no pulse, and ignore strobe edges that occurred during reset.

Verification
REQ-035 SHALL cover: write ADDR_RST, then bytes 01..0A, then checksum 0B -> wr_valid_out pulses once and wr_frame_out=0x0A09..01.
REQ-036 SHALL cover: the same frame with checksum 0C -> no pulse, wr_frame_out unchanged, STAT bit7=1; a further ADDR_PROC write -> STAT bit6=1.
REQ-037 SHALL cover: rd_frame_in=bytes 00..19, then read ADDR_RST (returns A5, rd_snap_out pulses), then 28 reads of ADDR_PROC -> 00..19, then the XOR of those bytes, then 00.
REQ-038 SHALL cover: a write to ADDR_PROC with isa_aen_in=1 -> ignored, and wr_cnt unchanged via STAT bit5.
REQ-039 SHALL cover: rst_in asserted after 5 written bytes, then a full frame with valid checksum -> exactly one commit, containing only the new frame.
REQ-040 SHALL cover: re-run of REQ-035 with W_BYTES=3 and R_BYTES=4 -> boundary counts correct.
